// File: rtl/vball_rom_server_if.sv
// Purpose: single 16-bit external memory request/acknowledge port that the
//          ROM server uses to reach the SDRAM controller.
// Signals:
//   req   server -> controller  request, held high until ack
//   addr  server -> controller  word-aligned byte address, stable while req
//   ack   controller -> server  1-cycle pulse, data valid in that cycle
//   data  controller -> server  16-bit word (byte 0 in [7:0], byte 1 in [15:8])
interface vball_rom_server_if;
  logic        req;
  logic [24:0] addr;
  logic        ack;
  logic [15:0] data;

  modport master (output req, output addr, input ack, input data);
  modport slave  (input req, input addr, output ack, output data);
endinterface

// File: rtl/vball_rom_server.sv
// Purpose: serves BG graphics and PCM ROM byte fetches from the vball core
//          over one shared 16-bit memory port.
//          - Each client keeps one cached 16-bit word.
//          - Byte-sequential fetches hit the cache without a memory access.
// Ports:
//   clk_sys, reset_n         clock, synchronous active-low reset
//   flush                    level, invalidates both caches while high
//   bg_read / bg_addr        BG request strobe and 19-bit byte address
//   bg_data                  BG byte, held until the next BG delivery
//   pcm_rom_read / _addr     PCM request strobe and 18-bit byte address
//   pcm_rom_data / _data_rdy PCM byte and its 1-cycle valid pulse
//   mem                      memory port (master side)
module vball_rom_server #(
  parameter logic [24:0] BG_BASE  = 25'h0_00000,
  parameter logic [24:0] PCM_BASE = 25'h1_00000
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       bg_read,
  input  logic [18:0]                bg_addr,
  output logic [7:0]                 bg_data,
  input  logic                       pcm_rom_read,
  input  logic [17:0]                pcm_rom_addr,
  output logic [7:0]                 pcm_rom_data,
  output logic                       pcm_rom_data_rdy,
  vball_rom_server_if.master         mem
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        owner_pcm_q, owner_pcm_d;   // client that owns the in-flight fetch
  logic        sel_hi_q, sel_hi_d;         // byte select of the in-flight fetch
  logic [17:0] fl_tag_q, fl_tag_d;         // word address of the in-flight fetch
  logic        mem_req_q, mem_req_d;
  logic [24:0] mem_addr_q, mem_addr_d;

  logic        bg_pend_q, bg_pend_d;
  logic [18:0] bg_addr_q, bg_addr_d;
  logic        bg_valid_q, bg_valid_d;
  logic [17:0] bg_tag_q, bg_tag_d;
  logic [15:0] bg_word_q, bg_word_d;
  logic [7:0]  bg_data_q, bg_data_d;

  logic        pcm_pend_q, pcm_pend_d;
  logic [17:0] pcm_addr_q, pcm_addr_d;
  logic        pcm_valid_q, pcm_valid_d;
  logic [16:0] pcm_tag_q, pcm_tag_d;
  logic [15:0] pcm_word_q, pcm_word_d;
  logic [7:0]  pcm_data_q, pcm_data_d;
  logic        pcm_rdy_q, pcm_rdy_d;

  logic        bg_hit, pcm_hit, bg_served, pcm_served;
  logic [7:0]  ack_byte;

  // A hit is never allowed while flush is high, even in the first flush
  // cycle before the valid bits have been cleared.
  assign bg_hit   = bg_valid_q  && !flush && (bg_tag_q  == bg_addr_q[18:1]);
  assign pcm_hit  = pcm_valid_q && !flush && (pcm_tag_q == pcm_addr_q[17:1]);
  assign ack_byte = sel_hi_q ? mem.data[15:8] : mem.data[7:0];

  always_comb begin
    state_d     = state_q;
    owner_pcm_d = owner_pcm_q;
    sel_hi_d    = sel_hi_q;
    fl_tag_d    = fl_tag_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    bg_valid_d  = bg_valid_q;
    bg_tag_d    = bg_tag_q;
    bg_word_d   = bg_word_q;
    bg_data_d   = bg_data_q;
    pcm_valid_d = pcm_valid_q;
    pcm_tag_d   = pcm_tag_q;
    pcm_word_d  = pcm_word_q;
    pcm_data_d  = pcm_data_q;
    pcm_rdy_d   = 1'b0;
    bg_served   = 1'b0;
    pcm_served  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bg_pend_q) begin
          bg_served = 1'b1;
          if (bg_hit) begin
            bg_data_d = bg_addr_q[0] ? bg_word_q[15:8] : bg_word_q[7:0];
          end else begin
            mem_req_d   = 1'b1;
            mem_addr_d  = BG_BASE + {6'b0, bg_addr_q[18:1], 1'b0};
            owner_pcm_d = 1'b0;
            sel_hi_d    = bg_addr_q[0];
            fl_tag_d    = bg_addr_q[18:1];
            state_d     = S_REQ;
          end
        end else if (pcm_pend_q) begin
          pcm_served = 1'b1;
          if (pcm_hit) begin
            pcm_data_d = pcm_addr_q[0] ? pcm_word_q[15:8] : pcm_word_q[7:0];
            pcm_rdy_d  = 1'b1;
          end else begin
            mem_req_d   = 1'b1;
            mem_addr_d  = PCM_BASE + {7'b0, pcm_addr_q[17:1], 1'b0};
            owner_pcm_d = 1'b1;
            sel_hi_d    = pcm_addr_q[0];
            fl_tag_d    = {1'b0, pcm_addr_q[17:1]};
            state_d     = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem.ack) begin
          mem_req_d = 1'b0;
          state_d   = S_DONE;
          if (owner_pcm_q) begin
            pcm_data_d = ack_byte;
            pcm_rdy_d  = 1'b1;
            if (!flush) begin
              pcm_valid_d = 1'b1;
              pcm_tag_d   = fl_tag_q[16:0];
              pcm_word_d  = mem.data;
            end
          end else begin
            bg_data_d = ack_byte;
            if (!flush) begin
              bg_valid_d = 1'b1;
              bg_tag_d   = fl_tag_q;
              bg_word_d  = mem.data;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      bg_valid_d  = 1'b0;
      pcm_valid_d = 1'b0;
    end

    // Pending is consumed when a request is served or issued; the in-flight
    // address lives in sel_hi/fl_tag, so a strobe during a fetch simply
    // queues the newest address behind it.
    bg_pend_d  = (bg_pend_q && !bg_served) || bg_read;
    bg_addr_d  = bg_read ? bg_addr : bg_addr_q;
    pcm_pend_d = (pcm_pend_q && !pcm_served) || pcm_rom_read;
    pcm_addr_d = pcm_rom_read ? pcm_rom_addr : pcm_addr_q;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      owner_pcm_q <= 1'b0;
      sel_hi_q    <= 1'b0;
      fl_tag_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      bg_pend_q   <= 1'b0;
      bg_addr_q   <= '0;
      bg_valid_q  <= 1'b0;
      bg_tag_q    <= '0;
      bg_word_q   <= '0;
      bg_data_q   <= '0;
      pcm_pend_q  <= 1'b0;
      pcm_addr_q  <= '0;
      pcm_valid_q <= 1'b0;
      pcm_tag_q   <= '0;
      pcm_word_q  <= '0;
      pcm_data_q  <= '0;
      pcm_rdy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_pcm_q <= owner_pcm_d;
      sel_hi_q    <= sel_hi_d;
      fl_tag_q    <= fl_tag_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      bg_pend_q   <= bg_pend_d;
      bg_addr_q   <= bg_addr_d;
      bg_valid_q  <= bg_valid_d;
      bg_tag_q    <= bg_tag_d;
      bg_word_q   <= bg_word_d;
      bg_data_q   <= bg_data_d;
      pcm_pend_q  <= pcm_pend_d;
      pcm_addr_q  <= pcm_addr_d;
      pcm_valid_q <= pcm_valid_d;
      pcm_tag_q   <= pcm_tag_d;
      pcm_word_q  <= pcm_word_d;
      pcm_data_q  <= pcm_data_d;
      pcm_rdy_q   <= pcm_rdy_d;
    end
  end

  assign mem.req          = mem_req_q;
  assign mem.addr         = mem_addr_q;
  assign bg_data          = bg_data_q;
  assign pcm_rom_data     = pcm_data_q;
  assign pcm_rom_data_rdy = pcm_rdy_q;

endmodule

// File: tb/tb_vball_rom_server.sv
module tb_vball_rom_server;
  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        bg_read = 1'b0;
  logic [18:0] bg_addr = '0;
  logic [7:0]  bg_data;
  logic        pcm_rom_read = 1'b0;
  logic [17:0] pcm_rom_addr = '0;
  logic [7:0]  pcm_rom_data;
  logic        pcm_rom_data_rdy;
  int          total = 0;
  int          bad = 0;
  int          rdy_cnt = 0;

  vball_rom_server_if mem_bus ();

  vball_rom_server dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .flush(flush),
    .bg_read(bg_read), .bg_addr(bg_addr), .bg_data(bg_data),
    .pcm_rom_read(pcm_rom_read), .pcm_rom_addr(pcm_rom_addr),
    .pcm_rom_data(pcm_rom_data), .pcm_rom_data_rdy(pcm_rom_data_rdy),
    .mem(mem_bus.master)
  );

  always #5 clk_sys = ~clk_sys;

  // Counts rdy pulses as seen at each rising edge (value of the prior cycle).
  always @(posedge clk_sys) if (pcm_rom_data_rdy === 1'b1) rdy_cnt <= rdy_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Stimulus helpers (no comparisons); all are entered and left at a negedge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk_sys);
  endtask

  task automatic pcm_strobe(input logic [17:0] a);
    pcm_rom_read = 1'b1; pcm_rom_addr = a; tick(); pcm_rom_read = 1'b0;
  endtask

  task automatic bg_strobe(input logic [18:0] a);
    bg_read = 1'b1; bg_addr = a; tick(); bg_read = 1'b0;
  endtask

  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (mem_bus.req === 1'b1) got = 1'b1;
      else tick();
    end
  endtask

  task automatic ack(input logic [15:0] d);
    mem_bus.ack = 1'b1; mem_bus.data = d; tick(); mem_bus.ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; tick(3);
    total++; if (mem_bus.req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", mem_bus.req); end
    total++; if (mem_bus.addr !== 25'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", mem_bus.addr); end
    total++; if (bg_data !== 8'h00 || pcm_rom_data !== 8'h00) begin bad++; $display("FAIL reset_data bg=%h pcm=%h want 00/00", bg_data, pcm_rom_data); end
    total++; if (pcm_rom_data_rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%b want=0", pcm_rom_data_rdy); end
    reset_n = 1'b1; tick();
  endtask

  task automatic test_pcm_miss();
    bit got; int c0;
    c0 = rdy_cnt;
    pcm_strobe(18'h00004);
    wait_req(got);
    total++; if (got !== 1'b1) begin bad++; $display("FAIL miss_req_timeout got=%b want=1", got); end
    total++; if (mem_bus.addr !== 25'h100004) begin bad++; $display("FAIL miss_addr got=%h want=100004", mem_bus.addr); end
    tick(5);
    total++; if (mem_bus.req !== 1'b1) begin bad++; $display("FAIL miss_req_held got=%b want=1", mem_bus.req); end
    ack(16'hBEEF);
    total++; if (pcm_rom_data !== 8'hEF || pcm_rom_data_rdy !== 1'b1) begin bad++; $display("FAIL miss_data got=%h/%b want=ef/1", pcm_rom_data, pcm_rom_data_rdy); end
    total++; if (mem_bus.req !== 1'b0) begin bad++; $display("FAIL miss_req_drop got=%b want=0", mem_bus.req); end
    tick();
    total++; if (pcm_rom_data_rdy !== 1'b0 || rdy_cnt - c0 !== 1) begin bad++; $display("FAIL miss_rdy_pulses rdy=%b count=%0d want 0/1", pcm_rom_data_rdy, rdy_cnt - c0); end
  endtask

  task automatic test_pcm_hit();
    pcm_strobe(18'h00005);
    total++; if (pcm_rom_data_rdy !== 1'b0 || mem_bus.req !== 1'b0) begin bad++; $display("FAIL hit_n1 rdy=%b req=%b want 0/0", pcm_rom_data_rdy, mem_bus.req); end
    tick();
    total++; if (pcm_rom_data !== 8'hBE || pcm_rom_data_rdy !== 1'b1 || mem_bus.req !== 1'b0) begin bad++; $display("FAIL hit_n2 data=%h rdy=%b req=%b want be/1/0", pcm_rom_data, pcm_rom_data_rdy, mem_bus.req); end
    tick();
    total++; if (pcm_rom_data_rdy !== 1'b0) begin bad++; $display("FAIL hit_rdy_width got=%b want=0", pcm_rom_data_rdy); end
  endtask

  task automatic test_simultaneous();
    bit got; int c0;
    c0 = rdy_cnt;
    bg_read = 1'b1; bg_addr = 19'h00010; pcm_rom_read = 1'b1; pcm_rom_addr = 18'h00100;
    tick(); bg_read = 1'b0; pcm_rom_read = 1'b0;
    wait_req(got);
    total++; if (got !== 1'b1 || mem_bus.addr !== 25'h000010) begin bad++; $display("FAIL sim_bg_first got=%b addr=%h want 1/000010", got, mem_bus.addr); end
    ack(16'h1234);
    total++; if (bg_data !== 8'h34 || pcm_rom_data_rdy !== 1'b0) begin bad++; $display("FAIL sim_bg_data data=%h rdy=%b want 34/0", bg_data, pcm_rom_data_rdy); end
    wait_req(got);
    total++; if (got !== 1'b1 || mem_bus.addr !== 25'h100100) begin bad++; $display("FAIL sim_pcm_second got=%b addr=%h want 1/100100", got, mem_bus.addr); end
    ack(16'h5678);
    total++; if (pcm_rom_data !== 8'h78 || pcm_rom_data_rdy !== 1'b1 || bg_data !== 8'h34) begin bad++; $display("FAIL sim_pcm_data pcm=%h rdy=%b bg=%h want 78/1/34", pcm_rom_data, pcm_rom_data_rdy, bg_data); end
    tick();
    total++; if (rdy_cnt - c0 !== 1) begin bad++; $display("FAIL sim_rdy_count got=%0d want=1", rdy_cnt - c0); end
  endtask

  task automatic test_bg_hit();
    bg_strobe(19'h00011);
    tick();
    total++; if (bg_data !== 8'h12 || mem_bus.req !== 1'b0) begin bad++; $display("FAIL bg_hit data=%h req=%b want 12/0", bg_data, mem_bus.req); end
  endtask

  task automatic test_back_to_back();
    bit got; int c0; int extra;
    c0 = rdy_cnt;
    pcm_strobe(18'h00000);
    wait_req(got);
    total++; if (got !== 1'b1 || mem_bus.addr !== 25'h100000) begin bad++; $display("FAIL b2b_first got=%b addr=%h want 1/100000", got, mem_bus.addr); end
    pcm_strobe(18'h00002);
    pcm_strobe(18'h00008);
    ack(16'hA55A);
    total++; if (pcm_rom_data !== 8'h5A || pcm_rom_data_rdy !== 1'b1) begin bad++; $display("FAIL b2b_data0 got=%h/%b want 5a/1", pcm_rom_data, pcm_rom_data_rdy); end
    wait_req(got);
    total++; if (got !== 1'b1 || mem_bus.addr !== 25'h100008) begin bad++; $display("FAIL b2b_second got=%b addr=%h want 1/100008", got, mem_bus.addr); end
    ack(16'hC3D4);
    total++; if (pcm_rom_data !== 8'hD4 || pcm_rom_data_rdy !== 1'b1) begin bad++; $display("FAIL b2b_data8 got=%h/%b want d4/1", pcm_rom_data, pcm_rom_data_rdy); end
    extra = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (mem_bus.req !== 1'b0) extra++; end
    total++; if (extra !== 0) begin bad++; $display("FAIL b2b_no_third req_cycles=%0d want=0", extra); end
    total++; if (rdy_cnt - c0 !== 2) begin bad++; $display("FAIL b2b_rdy_count got=%0d want=2", rdy_cnt - c0); end
  endtask

  task automatic test_reset_mid_req();
    bit got; int c0;
    pcm_strobe(18'h00020);
    wait_req(got);
    total++; if (got !== 1'b1) begin bad++; $display("FAIL rst_mid_req_timeout got=%b want=1", got); end
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    total++; if (mem_bus.req !== 1'b0 || pcm_rom_data !== 8'h00 || bg_data !== 8'h00 || pcm_rom_data_rdy !== 1'b0) begin bad++; $display("FAIL rst_mid_outputs req=%b pcm=%h bg=%h rdy=%b want 0/00/00/0", mem_bus.req, pcm_rom_data, bg_data, pcm_rom_data_rdy); end
    c0 = rdy_cnt;
    tick();
    ack(16'h1111);
    tick(2);
    total++; if (rdy_cnt - c0 !== 0 || pcm_rom_data !== 8'h00 || mem_bus.req !== 1'b0) begin bad++; $display("FAIL rst_late_ack rdy_count=%0d pcm=%h req=%b want 0/00/0", rdy_cnt - c0, pcm_rom_data, mem_bus.req); end
    test_pcm_miss();
  endtask

  task automatic test_flush();
    bit got;
    flush = 1'b1; tick();
    pcm_strobe(18'h00005);
    wait_req(got);
    total++; if (got !== 1'b1 || mem_bus.addr !== 25'h100004) begin bad++; $display("FAIL flush_no_hit got=%b addr=%h want 1/100004", got, mem_bus.addr); end
    ack(16'h1122);
    total++; if (pcm_rom_data !== 8'h11 || pcm_rom_data_rdy !== 1'b1) begin bad++; $display("FAIL flush_data got=%h/%b want 11/1", pcm_rom_data, pcm_rom_data_rdy); end
    tick(); flush = 1'b0; tick();
    pcm_strobe(18'h00005);
    wait_req(got);
    total++; if (got !== 1'b1 || mem_bus.addr !== 25'h100004) begin bad++; $display("FAIL flush_refetch got=%b addr=%h want 1/100004", got, mem_bus.addr); end
    ack(16'h3344);
    total++; if (pcm_rom_data !== 8'h33) begin bad++; $display("FAIL flush_refetch_data got=%h want=33", pcm_rom_data); end
    tick();
    pcm_strobe(18'h00004);
    total++; if (mem_bus.req !== 1'b0) begin bad++; $display("FAIL post_flush_hit_req got=%b want=0", mem_bus.req); end
    tick();
    total++; if (pcm_rom_data !== 8'h44 || pcm_rom_data_rdy !== 1'b1 || mem_bus.req !== 1'b0) begin bad++; $display("FAIL post_flush_hit data=%h rdy=%b req=%b want 44/1/0", pcm_rom_data, pcm_rom_data_rdy, mem_bus.req); end
    tick();
  endtask

  initial begin
    mem_bus.ack = 1'b0;
    mem_bus.data = 16'h0000;
    @(negedge clk_sys);
    test_reset();
    test_pcm_miss();
    test_pcm_hit();
    test_simultaneous();
    test_bg_hit();
    test_back_to_back();
    test_reset_mid_req();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
